led_serial_out: RTL
===================

# led_serial_out

Parametrised serial LED-driver output engine. It accepts one parallel frame of `c_chan` × `c_bits` grey levels over a valid/ready handshake and shifts it out MSB-first on a clock/data pair, then pulses a latch line. It sits between the frame source (demo pattern generator or future animation engine) and the chained LED driver ICs, replacing the fixed-format demo serializer. It runs off the divided system clock inside `lamp`.

## Interface
- `c_chan`, default 12: channels per frame (whole driver chain).
- `c_bits`, default 16: bits per channel.
- `c_div`, default 1: `i_clk` cycles per serial-clock half-period, ≥ 1.
- `c_lat`, default 4: `i_clk` cycles `o_lat` is held high, ≥ 1.
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_data`  in  `c_chan*c_bits`  frame; channel k occupies `[k*c_bits +: c_bits]`.
- `i_valid`  in  1  frame valid.
- `o_ready`  out  1  block idle, frame accepted when `i_valid && o_ready`.
- `o_clk`  out  1  serial clock to driver chain.
- `o_dai`  out  1  serial data to driver chain.
- `o_lat`  out  1  latch pulse.
- `o_done`  out  1  one-cycle pulse, frame fully latched.

## Operation
- N = `c_chan*c_bits` bits per frame. Order: channel `c_chan-1` first, MSB first within each channel, i.e. `i_data[N-1]` first, `i_data[0]` last.
- Reset values: `o_ready`=1, `o_clk`=0, `o_dai`=0, `o_lat`=0, `o_done`=0, state IDLE.
- States: IDLE → SHIFT_LO ↔ SHIFT_HI → LATCH → IDLE.
  - IDLE: `o_ready`=1. On accept, register `i_data` into the shift register, clear the bit counter and go to SHIFT_LO. `i_data` is a don't-care after the accept edge.
  - SHIFT_LO: `o_clk`=0, `o_dai`= current bit. After `c_div` cycles go to SHIFT_HI.
  - SHIFT_HI: `o_clk`=1, `o_dai` stable. After `c_div` cycles: if the bit counter is N-1, go to LATCH; otherwise shift, increment the counter and go to SHIFT_LO.
  - LATCH: `o_clk`=0, `o_dai`=0, `o_lat`=1 for `c_lat` cycles, then go to IDLE with `o_done`=1 for one cycle.
- `o_dai` changes only while `o_clk` is low. The driver samples on the `o_clk` rising edge, with setup ≥ `c_div` cycles and hold ≥ `c_div` cycles.
- `i_valid` while busy is ignored; the source holds it. No frame is dropped or overwritten mid-shift.
- `i_rst` mid-frame aborts immediately. All outputs return to their reset values asynchronously, with no latch pulse. The partial frame stays unlatched in the drivers.
- Bit counter width `$clog2(N)`; divide counter width `max(1,$clog2(c_div))`. No wrap: the counter never exceeds N-1.

## Timing
- Accept on edge T. Bit k low phase: cycles T+1+2k·`c_div` … +`c_div`-1. High phase: the next `c_div` cycles.
- `o_lat`=1: cycles T+1+2N·`c_div` … T+2N·`c_div`+`c_lat`.
- `o_done`=1 and `o_ready`=1: cycle T+1+2N·`c_div`+`c_lat`.
- If `i_valid` is held, the next accept is on that same cycle (back-to-back). The minimum frame period is 2N·`c_div`+`c_lat`+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- `lamp_pkg` holds the state encoding localparams (IDLE, SHIFT_LO, SHIFT_HI, LATCH) and the default driver-chain constants (`c_chan`, `c_bits`), shared with `lamp` and future frame sources.
- One sub-module, `tick_gen`: a `c_div` cycle counter producing a one-cycle phase-end strobe, restarted on accept. It is reusable by later PWM/animation blocks.

## Test plan
- Reset: assert `i_rst` asynchronously mid-cycle → all outputs go to reset values without waiting for a clock edge; `o_ready`=1 after release.
- Frame format (`c_chan`=3, `c_bits`=8, `c_div`=2, `c_lat`=4), `i_data`=0xA50FC3:
  - exactly 24 `o_clk` rising edges;
  - sampled bits are 1010 0101 0000 1111 1100 0011;
  - `o_lat` high at T+97…T+100;
  - `o_done` and `o_ready` at T+101.
- Back-to-back: `i_valid` held with frames 0xFFFFFF then 0x000000 → second accept at T+101; no glitch on `o_lat`/`o_clk` between frames.
- Busy ignore: change `i_data` and toggle `i_valid` during shift → serial output unchanged; the new frame is accepted only when `o_ready`=1.
- Reset mid-shift: assert `i_rst` at bit 10 → `o_lat` never rises; the next frame after reset shifts correctly from bit 0.
- Edge params: `c_div`=1, `c_lat`=1, `c_chan`=1, `c_bits`=1, `i_data`=1 → `o_clk` low 1 cycle then high 1 cycle with `o_dai`=1; `o_lat` high 1 cycle; `o_done` at T+4.

Source files
------------

// File: rtl/lamp_pkg.sv
// Shared lamp definitions: serializer state encoding and the default driver-chain geometry.
package lamp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_e;

  localparam int unsigned c_chan_dflt = 12;
  localparam int unsigned c_bits_dflt = 16;

  // Counter width that stays at least one bit for degenerate ranges.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/led_serial_out_if.sv
// Frame handshake between a frame source (master) and the LED serializer (slave).
interface led_serial_out_if #(
  parameter int unsigned c_width = 192
);
  logic [c_width-1:0] i_data;
  logic               i_valid;
  logic               o_ready;
  logic               o_done;

  modport master (output i_data, output i_valid, input o_ready, input o_done);
  modport slave  (input i_data, input i_valid, output o_ready, output o_done);
endinterface

// File: rtl/tick_gen.sv
// Free-running c_div cycle counter with a phase-end strobe; restart forces a fresh phase.
module tick_gen
  import lamp_pkg::*;
#(
  parameter int unsigned c_div = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);
  localparam int unsigned     c_w    = clog2_min1(c_div);
  localparam logic [c_w-1:0]  c_last = c_w'(c_div - 1);

  logic [c_w-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + c_w'(1);
    if (i_restart || (cnt_q == c_last)) cnt_d = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_tick = (cnt_q == c_last);
endmodule

// File: rtl/led_serial_out.sv
// Serial LED-driver output engine: shifts one parallel frame out MSB-first on o_clk/o_dai,
// then pulses o_lat for c_lat cycles and flags o_done.
module led_serial_out
  import lamp_pkg::*;
#(
  parameter int unsigned c_chan = c_chan_dflt,
  parameter int unsigned c_bits = c_bits_dflt,
  parameter int unsigned c_div  = 1,
  parameter int unsigned c_lat  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  led_serial_out_if.slave     frame,
  output logic                o_clk,
  output logic                o_dai,
  output logic                o_lat
);
  localparam int unsigned      c_n        = c_chan * c_bits;
  localparam int unsigned      c_bw       = clog2_min1(c_n);
  localparam int unsigned      c_lw       = clog2_min1(c_lat);
  localparam logic [c_bw-1:0]  c_last_bit = c_bw'(c_n - 1);
  localparam logic [c_lw-1:0]  c_last_lat = c_lw'(c_lat - 1);

  state_e          state_q, state_d;
  logic [c_n-1:0]  sreg_q, sreg_d;
  logic [c_bw-1:0] bit_cnt_q, bit_cnt_d;
  logic [c_lw-1:0] lat_cnt_q, lat_cnt_d;
  logic            clk_q, clk_d;
  logic            dai_q, dai_d;
  logic            lat_q, lat_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            accept;
  logic            tick;

  assign accept = (state_q == IDLE) && frame.i_valid;

  tick_gen #(.c_div(c_div)) u_tick (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_restart (accept),
    .o_tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    lat_cnt_d = lat_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame.i_valid) begin
          sreg_d    = frame.i_data;
          bit_cnt_d = '0;
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (tick) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (tick) begin
          if (bit_cnt_q == c_last_bit) begin
            lat_cnt_d = '0;
            state_d   = LATCH;
          end else begin
            sreg_d    = sreg_q << 1;
            bit_cnt_d = bit_cnt_q + c_bw'(1);
            state_d   = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        if (lat_cnt_q == c_last_lat) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + c_lw'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    clk_d   = (state_d == SHIFT_HI);
    dai_d   = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) && sreg_d[c_n-1];
    lat_d   = (state_d == LATCH);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      lat_cnt_q <= '0;
      clk_q     <= 1'b0;
      dai_q     <= 1'b0;
      lat_q     <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      clk_q     <= clk_d;
      dai_q     <= dai_d;
      lat_q     <= lat_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign o_clk         = clk_q;
  assign o_dai         = dai_q;
  assign o_lat         = lat_q;
  assign frame.o_ready = ready_q;
  assign frame.o_done  = done_q;
endmodule
